// File: rtl/spm_bank_conflict_scheduler_pkg.sv
// Shared SPM address geometry, decoded field types and scheduler state encoding.
// Optional feature macro used by the scheduler: SPM_LOAD_BROADCAST_EN.
package spm_bank_conflict_scheduler_pkg;

  localparam int SM_PROCESSING_ELEMENTS     = 16;
  localparam int SM_BYTE_ADDRESS_LEN        = 2;
  localparam int SM_MEMORY_BANK_ADDRESS_LEN = 4;
  localparam int SM_ADDRESS_LEN             = 16;
  localparam int SM_ENTRY_ADDRESS_LEN       = SM_ADDRESS_LEN - SM_MEMORY_BANK_ADDRESS_LEN
                                              - SM_BYTE_ADDRESS_LEN;
  localparam int SM_MEMORY_BANKS            = 2 ** SM_MEMORY_BANK_ADDRESS_LEN;
  localparam int SM_ENTRY_LSB               = SM_BYTE_ADDRESS_LEN + SM_MEMORY_BANK_ADDRESS_LEN;

  typedef logic [SM_ADDRESS_LEN-1:0]             sm_address_t;
  typedef logic [SM_ENTRY_ADDRESS_LEN-1:0]       sm_entry_address_t;
  typedef logic [SM_MEMORY_BANK_ADDRESS_LEN-1:0] sm_bank_address_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } spm_sched_state_t;

endpackage

// File: rtl/spm_bank_grant_select.sv
// Fixed-priority find-first over one bank's requesting lanes; lowest lane index wins.
module spm_bank_grant_select #(
  parameter int NUM_LANES = 16,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req_i,
  output logic                 valid_o,
  output logic [LANE_W-1:0]    lane_o
);

  always_comb begin
    valid_o = |req_i;
    lane_o  = '0;
    // Descending scan so the last (lowest-index) match overwrites earlier ones.
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (req_i[i]) lane_o = LANE_W'(i);
    end
  end

endmodule

// File: rtl/spm_bank_conflict_scheduler.sv
// Splits one SIMD scratchpad request into bank-conflict-free issue slots.
// Define SPM_LOAD_BROADCAST_EN to let loads to an identical address share one slot.
module spm_bank_conflict_scheduler
  import spm_bank_conflict_scheduler_pkg::*;
#(
  parameter int NUM_LANES = SM_PROCESSING_ELEMENTS,
  parameter int NUM_BANKS = SM_MEMORY_BANKS,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_is_store,
  input  logic [NUM_LANES-1:0]                req_mask,
  input  sm_address_t [NUM_LANES-1:0]         req_address,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_BANKS-1:0]                out_bank_valid,
  output sm_entry_address_t [NUM_BANKS-1:0]   out_bank_offset,
  output logic [NUM_BANKS-1:0][LANE_W-1:0]    out_bank_lane,
  output logic [NUM_LANES-1:0]                out_lane_mask,
  output logic                                out_is_store,
  output logic                                out_last
);

  spm_sched_state_t            state_q, state_d;
  logic [NUM_LANES-1:0]        pending_q, pending_d;
  logic                        is_store_q, is_store_d;
  sm_address_t [NUM_LANES-1:0] addr_q;

  sm_bank_address_t [NUM_LANES-1:0]        lane_bank;
  logic [NUM_BANKS-1:0][NUM_LANES-1:0]     bank_req;
  logic [NUM_BANKS-1:0]                    grant_valid;
  logic [NUM_BANKS-1:0][LANE_W-1:0]        grant_lane;
  logic                                    fire;

  assign out_valid    = (state_q == ISSUE);
  assign out_is_store = out_valid & is_store_q;
  assign out_last     = out_valid & ~|(pending_q & ~out_lane_mask);
  assign fire         = out_valid & out_ready;

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_bank[l] = addr_q[l][SM_BYTE_ADDRESS_LEN +: SM_MEMORY_BANK_ADDRESS_LEN];
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        bank_req[b][l] = pending_q[l] && (lane_bank[l] == sm_bank_address_t'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    spm_bank_grant_select #(
      .NUM_LANES (NUM_LANES),
      .LANE_W    (LANE_W)
    ) u_grant (
      .req_i   (bank_req[b]),
      .valid_o (grant_valid[b]),
      .lane_o  (grant_lane[b])
    );
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
    out_bank_valid  = grant_valid;
    out_bank_offset = '0;
    out_bank_lane   = '0;
    out_lane_mask   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (grant_valid[b]) begin
        out_lane_mask[grant_lane[b]] = 1'b1;
        out_bank_lane[b]             = grant_lane[b];
        out_bank_offset[b]           = addr_q[grant_lane[b]][SM_ENTRY_LSB +: SM_ENTRY_ADDRESS_LEN];
      end
    end
`ifdef SPM_LOAD_BROADCAST_EN
    // A load lane rides along when its full address equals its bank winner's address.
    if (!is_store_q) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (pending_q[l] && grant_valid[lane_bank[l]] &&
            (addr_q[grant_lane[lane_bank[l]]] == addr_q[l])) begin
          out_lane_mask[l] = 1'b1;
        end
      end
    end
`endif
  end

`ifndef SPM_LOAD_BROADCAST_EN
  // Byte-select bits only matter for broadcast address matching.
  logic unused_byte_bits;
  always_comb begin
    unused_byte_bits = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      unused_byte_bits = unused_byte_bits ^ (^addr_q[l][SM_BYTE_ADDRESS_LEN-1:0]);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    is_store_d = is_store_q;
    req_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          pending_d  = req_mask;
          is_store_d = req_is_store;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (fire) begin
          pending_d = pending_q & ~out_lane_mask;
          if (out_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      is_store_q <= is_store_d;
    end
  end

  // NOTE: address storage is not reset; it is only read for lanes set in pending_q, which reset clears.
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) addr_q <= req_address;
  end

endmodule
